// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Multi-cycle issue controller on the initiator side of an external,
//   purely combinational 16-bit ALU. Accepts one instruction per
//   valid/ready handshake, reads operands from an internal 8-entry
//   register file, shifts operand B, drives the ALU, captures the result
//   and flags, then writes back.
//
//   Instruction: {opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0]}
//                imm8 = [7:0] for MOV Rn,#imm8
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   instr        in   instruction word, sampled on the accept edge only
//   instr_valid  in   instruction presented
//   instr_ready  out  high only in IDLE
//   alu_ain      out  registered A operand
//   alu_bin      out  registered, shifted B operand
//   alu_op       out  00 ADD, 01 SUB, 10 AND, 11 NOT-B
//   alu_out      in   ALU result
//   alu_z        in   ALU flags {overflow, negative, zero}
//   result       out  C register
//   status       out  status register, same bit order as alu_z
//   done         out  one-cycle pulse in the final cycle of an instruction
//
// Configuration
//   ILLEGAL_TRAP_EN  when defined, an illegal instruction parks the
//                    controller in TRAP (status=111) until reset; when
//                    undefined it completes as a NOP.

module alu_issue_ctrl #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] REG_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_z,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        status,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_READ_A = 3'd2;
  localparam logic [2:0] S_READ_B = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'd6;
`endif

  logic [2:0]        state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [8];

  logic [2:0]        f_opcode;
  logic [1:0]        f_op;
  logic [2:0]        f_rn;
  logic [2:0]        f_rd;
  logic [1:0]        f_sh;
  logic [2:0]        f_rm;
  logic              is_movi;
  logic              is_movr;
  logic              is_alu;
  logic              is_cmp;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] shifted;

  assign f_opcode = ir[15:13];
  assign f_op     = ir[12:11];
  assign f_rn     = ir[10:8];
  assign f_rd     = ir[7:5];
  assign f_sh     = ir[4:3];
  assign f_rm     = ir[2:0];

  assign is_movi  = (f_opcode == 3'b110) && (f_op == 2'b10);
  assign is_movr  = (f_opcode == 3'b110) && (f_op == 2'b00);
  assign is_alu   = (f_opcode == 3'b101);
  assign is_cmp   = is_alu && (f_op == 2'b01);
  assign imm_sext = {{(DATA_W-8){ir[7]}}, ir[7:0]};

  always_comb begin
    shifted = rf[f_rm];
    case (f_sh)
      2'b01:   shifted = {rf[f_rm][DATA_W-2:0], 1'b0};
      2'b10:   shifted = {1'b0, rf[f_rm][DATA_W-1:1]};
      2'b11:   shifted = {rf[f_rm][DATA_W-1], rf[f_rm][DATA_W-1:1]};
      default: shifted = rf[f_rm];
    endcase
  end

  assign instr_ready = (state == S_IDLE);
  assign done        = (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      alu_ain <= '0;
      alu_bin <= '0;
      alu_op  <= '0;
      result  <= '0;
      status  <= '0;
      for (int unsigned i = 0; i < 8; i++) rf[i] <= REG_RESET;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_movi) begin
            result <= imm_sext;
            state  <= S_WRITE;
          end else if (is_movr || is_alu) begin
            state <= S_READ_A;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            status <= 3'b111;
            state  <= S_TRAP;
`else
            state  <= S_WRITE;
`endif
          end
        end
        S_READ_A: begin
          // register MOV runs as ADD with A forced to zero
          alu_ain <= is_movr ? '0 : rf[f_rn];
          alu_op  <= is_movr ? 2'b00 : f_op;
          state   <= S_READ_B;
        end
        S_READ_B: begin
          alu_bin <= shifted;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_out;
          if (is_alu) status <= alu_z;
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (is_movi)                         rf[f_rn] <= result;
          else if (is_movr || (is_alu && !is_cmp)) rf[f_rd] <= result;
          state <= S_IDLE;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
//   Expected values come from an instruction-level reference model
//   (register array, status, result, held operands).
//   Honours ILLEGAL_TRAP_EN the same way as the design.

module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_ain;
  logic [15:0] alu_bin;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic [2:0]  alu_z;
  logic [15:0] result;
  logic [2:0]  status;
  logic        done;

  logic        force_en;
  logic [2:0]  force_val;

  int ncmp = 0;
  int nerr = 0;

  // reference model state
  logic [15:0] mrf [8];
  logic [15:0] m_res;
  logic [2:0]  m_st;
  logic [15:0] m_ain;
  logic [15:0] m_bin;
  logic [1:0]  m_op;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(16), .REG_RESET(16'h0000)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_ain(alu_ain), .alu_bin(alu_bin),
    .alu_op(alu_op), .alu_out(alu_out), .alu_z(alu_z), .result(result),
    .status(status), .done(done)
  );

  // behavioural ALU
  logic [15:0] alu_res;
  logic        alu_v;
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_res = alu_ain + alu_bin;
        alu_v   = (alu_ain[15] == alu_bin[15]) && (alu_res[15] != alu_ain[15]);
      end
      2'b01: begin
        alu_res = alu_ain - alu_bin;
        alu_v   = (alu_ain[15] != alu_bin[15]) && (alu_res[15] != alu_ain[15]);
      end
      2'b10:   alu_res = alu_ain & alu_bin;
      default: alu_res = ~alu_bin;
    endcase
  end
  assign alu_out = alu_res;
  assign alu_z   = force_en ? force_val : {alu_v, alu_res[15], alu_res == 16'h0000};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] opc, input logic [1:0] op,
                                      input logic [2:0] rn, input logic [2:0] rd,
                                      input logic [1:0] sh, input logic [2:0] rm);
    return {opc, op, rn, rd, sh, rm};
  endfunction

  function automatic bit legal(input logic [15:0] i);
    return (i[15:13] == 3'b101) ||
           (i[15:13] == 3'b110 && (i[12:11] == 2'b00 || i[12:11] == 2'b10));
  endfunction

  function automatic logic [15:0] shiftv(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'b01:   return v + v;
      2'b10:   return v / 16'd2;
      2'b11:   return (v / 16'd2) | (v & 16'h8000);
      default: return v;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
    m_res = '0; m_st = '0; m_ain = '0; m_bin = '0; m_op = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Present ins, wait for the accept edge, return cycles until done (0 = none).
  task automatic issue(input logic [15:0] ins, output int lat);
    int w;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_issue", instr_ready, 1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) chk("ready_low_decode", instr_ready, 0);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input logic [15:0] ins);
    logic [2:0]  opc, rn, rd, rm, wdst, flags, e_st;
    logic [1:0]  op, sh, e_op;
    logic [15:0] a, b, r, e_ain, e_bin;
    bit          wr, movr;
    int          e_lat, lat, sa, sb, s;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8]; rd = ins[7:5];
    sh = ins[4:3]; rm = ins[2:0];
    e_ain = m_ain; e_bin = m_bin; e_op = m_op; e_st = m_st; r = m_res;
    wr = 1'b0; wdst = '0; e_lat = 2;
    if (opc == 3'b110 && op == 2'b10) begin
      r = {{8{ins[7]}}, ins[7:0]};
      wr = 1'b1; wdst = rn;
    end else if (legal(ins)) begin
      movr = (opc == 3'b110);
      a = movr ? 16'h0000 : mrf[rn];
      b = shiftv(mrf[rm], sh);
      e_op = movr ? 2'b00 : op;
      e_ain = a; e_bin = b; e_lat = 5;
      sa = $signed(a); sb = $signed(b);
      flags = 3'b000;
      case (e_op)
        2'b00: begin r = a + b; s = sa + sb; flags[2] = (s > 32767) || (s < -32768); end
        2'b01: begin r = a - b; s = sa - sb; flags[2] = (s > 32767) || (s < -32768); end
        2'b10: r = a & b;
        default: r = ~b;
      endcase
      flags[1] = r[15];
      flags[0] = (r == 16'h0000);
      if (!movr) e_st = force_en ? force_val : flags;
      wr = movr || (op != 2'b01);
      wdst = rd;
    end
    issue(ins, lat);
    chk("latency", lat, e_lat);
    chk("result", result, r);
    chk("status", status, e_st);
    chk("alu_ain", alu_ain, e_ain);
    chk("alu_bin", alu_bin, e_bin);
    chk("alu_op", alu_op, e_op);
    if (wr) mrf[wdst] = r;
    m_res = r; m_st = e_st; m_ain = e_ain; m_bin = e_bin; m_op = e_op;
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("ready_after", instr_ready, 1);
  endtask

  initial begin
    logic [15:0] ins;
    bit          saw_done;
    int          sel;
    reset = 1'b1; instr = '0; instr_valid = 1'b0;
    force_en = 1'b0; force_val = '0;
    model_reset();
    do_reset();

    // reset state
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_status", status, 0);
    chk("rst_ain", alu_ain, 0);
    chk("rst_bin", alu_bin, 0);
    chk("rst_op", alu_op, 0);

    // 1: MOV R0,#7
    run(16'hD007);
    chk("t1_result", result, 16'h0007);
    // 2: MOV R1,#-2 ; ADD R2,R1,R0
    run(16'hD1FE);
    run(16'hA140);
    chk("t2_ain", alu_ain, 16'hFFFE);
    chk("t2_bin", alu_bin, 16'h0007);
    chk("t2_result", result, 16'h0005);
    // 3: CMP R0,R0, then read R0 back via MOV R0,R0
    run(16'hA800);
    chk("t3_status", status, 3'b001);
    chk("t3_op", alu_op, 2'b01);
    run(enc(3'b110, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0));
    chk("t3_r0_kept", result, 16'h0007);
    // 4: MVN R3,R0,LSL1, plain and with forced flags
    run(16'hB868);
    chk("t4_result", result, 16'hFFF1);
    chk("t4_status", status, 3'b010);
    force_en = 1'b1; force_val = 3'b100;
    run(16'hB868);
    force_en = 1'b0;
    chk("t4_forced_status", status, 3'b100);

`ifndef ILLEGAL_TRAP_EN
    // 6: illegal completes as NOP
    run(16'hE000);
    chk("t6_status_kept", status, 3'b100);
`endif

    // 5: reset during EXEC of ADD
    @(negedge clk);
    instr = 16'hA140; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("t5_ready", instr_ready, 1);
    chk("t5_status", status, 3'b000);
    chk("t5_result", result, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("t5_no_done", saw_done, 0);

    // randomized sequence
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 1) begin
        ins = enc(3'b110, 2'b10, 3'($urandom_range(0, 7)), 3'd0, 2'd0, 3'd0);
        ins[7:0] = 8'($urandom);
      end else if (sel == 2) begin
        ins = enc(3'b110, 2'b00, 3'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
`ifndef ILLEGAL_TRAP_EN
      end else if (sel == 9) begin
        ins = 16'($urandom);
        for (int t = 0; t < 50 && legal(ins); t++) ins = 16'($urandom);
        if (legal(ins)) ins = 16'hE000;
`endif
      end else begin
        ins = enc(3'b101, 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
      end
      run(ins);
    end

    // read every register back
    for (int i = 0; i < 8; i++)
      run(enc(3'b110, 2'b00, 3'd0, 3'(i), 2'b00, 3'(i)));

`ifdef ILLEGAL_TRAP_EN
    // 6: illegal traps until reset
    @(negedge clk);
    instr = 16'hE000; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    saw_done = 1'b0;
    sel = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (instr_ready) sel++;
    end
    chk("t6_trap_no_done", saw_done, 0);
    chk("t6_trap_ready_cycles", sel, 0);
    chk("t6_trap_status", status, 3'b111);
    do_reset();
    chk("t6_reset_ready", instr_ready, 1);
    chk("t6_reset_status", status, 3'b000);
    run(16'hD007);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
